// File: rtl/ser2par_pkg.sv
// Shared state encoding and default word width for the serial-to-parallel converter.
package ser2par_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/ser2par_bit_cnt.sv
// Saturating accepted-bit counter; done flags the bit that completes a frame.
module ser2par_bit_cnt #(
  parameter int FRAME = 16,
  parameter int CW    = $clog2(FRAME + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          done
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CW'(FRAME))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign done  = inc && !clr && (count_q == CW'(FRAME - 1));

endmodule

// File: rtl/ser2par_16bit.sv
// Serial-to-parallel converter with hold-until-consumed output.
// Define SER2PAR_PARITY_EN to expect a trailing even-parity bit per frame.
module ser2par_16bit
  import ser2par_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             parity_err
);

`ifdef SER2PAR_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_shift;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             perr_q, perr_d;
  logic [CW-1:0]    cnt;
  logic             cnt_done, cnt_clr, accept, data_bit, frame_perr;

  assign ser_ready = (state_q != HOLD);
  assign accept    = ser_valid & ser_ready;
  assign cnt_clr   = clr | ((state_q == HOLD) & out_ready);
  // Only the first WIDTH bits of a frame are data; a parity bit never enters the shifter.
  assign data_bit  = (cnt < CW'(WIDTH));

  ser2par_bit_cnt #(.FRAME(FRAME), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (accept),
    .count(cnt),
    .done (cnt_done)
  );

  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shift = {sreg_q[WIDTH-2:0], ser_in};
    end else begin : g_lsb
      assign sreg_shift = {ser_in, sreg_q[WIDTH-1:1]};
    end
  endgenerate

`ifdef SER2PAR_PARITY_EN
  assign frame_perr = (^sreg_q) ^ ser_in;
`else
  assign frame_perr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    par_out_d = par_out_q;
    perr_d    = perr_q;
    if (clr) begin
      state_d = IDLE;
      sreg_d  = '0;
      perr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, SHIFT: begin
          if (accept) begin
            if (data_bit) sreg_d = sreg_shift;
            if (cnt_done) begin
              state_d   = HOLD;
              par_out_d = data_bit ? sreg_shift : sreg_q;
              sreg_d    = '0;
              perr_d    = frame_perr;
            end else begin
              state_d = SHIFT;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      par_out_q <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      par_out_q <= par_out_d;
      perr_q    <= perr_d;
    end
  end

  assign par_out    = par_out_q;
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q == SHIFT);
  assign parity_err = perr_q;

endmodule

// File: tb/tb_ser2par_16bit.sv
// Self-checking bench: an MSB-first and an LSB-first instance share one serial stream.
module tb_ser2par_16bit;

`ifdef SER2PAR_PARITY_EN
  localparam int FRAME = 17;
  localparam bit PAR_ON = 1'b1;
`else
  localparam int FRAME = 16;
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr, ser_in, ser_valid, out_ready;
  logic        ser_ready, out_valid, busy, parity_err;
  logic [15:0] par_out;
  logic        l_ser_ready, l_out_valid, l_busy, l_parity_err;
  logic [15:0] l_par_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ser2par_16bit #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .par_out(par_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .parity_err(parity_err)
  );

  ser2par_16bit #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .clr(clr), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(l_ser_ready), .par_out(l_par_out), .out_valid(l_out_valid),
    .out_ready(out_ready), .busy(l_busy), .parity_err(l_parity_err)
  );

  typedef struct {
    logic [15:0] din;      // wire order: din[15] is sent first
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit k on the wire lands at par_out[15-k] (MSB-first) or par_out[k] (LSB-first).
  function automatic logic [15:0] ref_lsb(input logic [15:0] w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k] = w[15 - k];
    return r;
  endfunction

  task automatic send_word(input logic [15:0] w, input int gap, input logic pbit);
    logic [16:0] fr;
    fr = {w, pbit};
    for (int i = 0; i < FRAME; i++) begin
      chk("ready_before_bit", ser_ready, 1);
      ser_valid = 1'b1;
      ser_in    = fr[16 - i];
      tick();
      ser_valid = 1'b0;
      if (i < FRAME - 1) begin
        chk("busy_mid", busy, 1);
        chk("count_mid", dut.u_cnt.count, i + 1);
        chk("out_valid_mid", out_valid, 0);
        for (int g = 0; g < gap; g++) begin
          ser_in = 1'($urandom_range(0, 1));
          tick();
        end
        if (gap > 0) chk("count_gap", dut.u_cnt.count, i + 1);
      end
    end
  endtask

  task automatic check_word(input logic [15:0] em, input logic [15:0] el, input logic ep);
    chk("out_valid_done", out_valid, 1);
    chk("busy_done", busy, 0);
    chk("ready_done", ser_ready, 0);
    chk("par_out_msb", par_out, em);
    chk("par_out_lsb", l_par_out, el);
    chk("parity_err", parity_err, ep);
    chk("parity_err_lsb", l_parity_err, ep);
  endtask

  task automatic consume(input logic [15:0] em, input logic [15:0] el);
    out_ready = 1'b1;
    ser_valid = 1'($urandom_range(0, 1));
    ser_in    = 1'($urandom_range(0, 1));
    tick();
    out_ready = 1'b0;
    ser_valid = 1'b0;
    chk("out_valid_after_take", out_valid, 0);
    chk("ready_after_take", ser_ready, 1);
    chk("count_after_take", dut.u_cnt.count, 0);
    chk("par_out_kept_msb", par_out, em);
    chk("par_out_kept_lsb", l_par_out, el);
  endtask

  initial begin
    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'hC3A5};
    vecs[1] = '{16'hC3A5, 16'hC3A5, 16'hA5C3};
    vecs[2] = '{16'h0001, 16'h0001, 16'h8000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'h1234, 16'h1234, 16'h2C48};
    vecs[5] = '{16'h00FF, 16'h00FF, 16'hFF00};

    clr = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_par_out", par_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ser_ready, 1);
    chk("rst_parity_err", parity_err, 0);
    chk("rst_count", dut.u_cnt.count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table: each row checks both bit orders on the same stream.
    for (int r = 0; r < 6; r++) begin
      send_word(vecs[r].din, 0, ^vecs[r].din);
      check_word(vecs[r].exp_msb, vecs[r].exp_lsb, 1'b0);
      consume(vecs[r].exp_msb, vecs[r].exp_lsb);
    end

    // Backpressure with junk bits offered while held.
    send_word(16'hA5C3, 0, ^16'hA5C3);
    check_word(16'hA5C3, 16'hC3A5, 1'b0);
    for (int c = 0; c < 5; c++) begin
      ser_valid = 1'b1;
      ser_in    = 1'($urandom_range(0, 1));
      tick();
      chk("bp_ready", ser_ready, 0);
      chk("bp_count", dut.u_cnt.count, FRAME);
      chk("bp_par_out", par_out, 16'hA5C3);
      chk("bp_out_valid", out_valid, 1);
    end
    consume(16'hA5C3, 16'hC3A5);
    send_word(16'h1234, 0, ^16'h1234);
    check_word(16'h1234, 16'h2C48, 1'b0);
    consume(16'h1234, 16'h2C48);

    // Gaps: valid pattern 1,0,0,1,...
    send_word(16'hFFFF, 2, 1'b0);
    check_word(16'hFFFF, 16'hFFFF, 1'b0);
    consume(16'hFFFF, 16'hFFFF);

    // clr after 7 bits, clr wins over a simultaneous valid bit.
    for (int i = 0; i < 7; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'(i & 1);
      tick();
    end
    clr = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    tick();
    clr = 1'b0; ser_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_count", dut.u_cnt.count, 0);
    chk("clr_ready", ser_ready, 1);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_par_out_kept", par_out, 16'hFFFF);
    send_word(16'h00FF, 0, ^16'h00FF);
    check_word(16'h00FF, 16'hFF00, 1'b0);
    consume(16'h00FF, 16'hFF00);

    // Async reset after 9 bits, checked between clock edges.
    for (int i = 0; i < 9; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'($urandom_range(0, 1));
      tick();
    end
    ser_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_par_out", par_out, 0);
    chk("arst_par_out_lsb", l_par_out, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_ready", ser_ready, 1);
    chk("arst_count", dut.u_cnt.count, 0);
    chk("arst_parity_err", parity_err, 0);
    tick();
    rst = 1'b0;

`ifdef SER2PAR_PARITY_EN
    send_word(16'h0001, 0, 1'b1);
    check_word(16'h0001, 16'h8000, 1'b0);
    consume(16'h0001, 16'h8000);
    send_word(16'h0001, 0, 1'b0);
    check_word(16'h0001, 16'h8000, 1'b1);
    consume(16'h0001, 16'h8000);
    chk("perr_kept_after_take", parity_err, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("perr_clr", parity_err, 0);
    chk("perr_clr_par_out", par_out, 16'h0001);
`endif

    // Randomized words, gaps, parity bits and hold times.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] w;
      logic        pb, ep;
      int          gap, hold;
      w    = 16'($urandom);
      pb   = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      ep   = PAR_ON ? ((^w) ^ pb) : 1'b0;
      send_word(w, gap, pb);
      check_word(w, ref_lsb(w), ep);
      for (int h = 0; h < hold; h++) begin
        ser_valid = 1'($urandom_range(0, 1));
        ser_in    = 1'($urandom_range(0, 1));
        tick();
        chk("rnd_hold_ready", ser_ready, 0);
        chk("rnd_hold_par_out", par_out, w);
      end
      consume(w, ref_lsb(w));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
